// File: rtl/bus_demux_1_3.sv
// Steers one bus word to one of three single-entry holding channels with
// valid/ack flow control; select code 2'b11 drops the word and counts it.
module bus_demux_1_3 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ack,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ack,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ack,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chState_t;

  chState_t         r_state [3];
  logic [WIDTH-1:0] r_data  [3];
  logic [CNT_W-1:0] r_dropCnt;

  logic [2:0] w_ack;
  logic       w_ready;
  logic       w_accept;

  assign w_ack = {out2_ack, out1_ack, out0_ack};

  // A channel is writable when empty or when its consumer drains it this cycle.
  always_comb begin
    w_ready = 1'b1;
    case (in_sel)
      2'b00:   w_ready = (r_state[0] == EMPTY) | w_ack[0];
      2'b01:   w_ready = (r_state[1] == EMPTY) | w_ack[1];
      2'b10:   w_ready = (r_state[2] == EMPTY) | w_ack[2];
      default: w_ready = 1'b1;
    endcase
  end

  assign w_accept = in_valid & w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        r_state[c] <= EMPTY;
        r_data[c]  <= '0;
      end
      r_dropCnt <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (w_accept && (in_sel == 2'(c))) begin
          r_state[c] <= FULL;
          r_data[c]  <= in_data;
        end else if (w_ack[c] && (r_state[c] == FULL)) begin
          r_state[c] <= EMPTY;
        end
      end
      if (w_accept && (in_sel == 2'b11) && (r_dropCnt != {CNT_W{1'b1}})) begin
        r_dropCnt <= r_dropCnt + 1'b1;
      end
    end
  end

  assign in_ready   = w_ready;
  assign out0_data  = r_data[0];
  assign out1_data  = r_data[1];
  assign out2_data  = r_data[2];
  assign out0_valid = (r_state[0] == FULL);
  assign out1_valid = (r_state[1] == FULL);
  assign out2_valid = (r_state[2] == FULL);
  assign drop_cnt   = r_dropCnt;

endmodule

// File: tb/tb_bus_demux_1_3.sv
// Directed and randomized bench for bus_demux_1_3 against a channel-level
// reference model; the drop counter is narrowed so saturation is reachable.
module tb_bus_demux_1_3;

  localparam int WIDTH    = 8;
  localparam int CNT_W    = 2;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data, out2_data;
  logic             out0_valid, out1_valid, out2_valid;
  logic             out0_ack, out1_ack, out2_ack;
  logic [CNT_W-1:0] drop_cnt;

  bus_demux_1_3 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ack(out0_ack),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ack(out1_ack),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ack(out2_ack),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model: what each channel holds and how many words were dropped.
  bit [2:0]         expValid;
  logic [WIDTH-1:0] expData [3];
  int               expDrop;
  bit               lastStalled;

  task automatic modelReset();
    expValid = '0;
    for (int c = 0; c < 3; c++) expData[c] = '0;
    expDrop = 0;
    lastStalled = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [2:0]       obsV;
    logic [WIDTH-1:0] obsD [3];
    obsV = {out2_valid, out1_valid, out0_valid};
    obsD[0] = out0_data;
    obsD[1] = out1_data;
    obsD[2] = out2_data;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("%s_valid%0d", tag, c), 32'(obsV[c]), 32'(expValid[c]));
      checkOutput($sformatf("%s_data%0d", tag, c), 32'(obsD[c]), 32'(expData[c]));
    end
    checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'(expDrop));
  endtask

  // Drives one cycle from just after a falling edge, checks the ready answer,
  // advances the model across the rising edge and checks the registered state.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                               input logic [2:0] ack, input string tag);
    bit expReady;
    bit accept;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    {out2_ack, out1_ack, out0_ack} = ack;
    #1;
    expReady = (s == 2'b11) || !expValid[s] || ack[s];
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'(expReady));
    accept = v && expReady;
    lastStalled = v && !expReady;
    for (int c = 0; c < 3; c++) begin
      if (accept && s == 2'(c)) begin
        expValid[c] = 1'b1;
        expData[c]  = d;
      end else if (ack[c]) begin
        expValid[c] = 1'b0;
      end
    end
    if (accept && s == 2'b11 && expDrop < DROP_MAX) expDrop = expDrop + 1;
    @(posedge clk);
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    int dropSeq [5] = '{1, 2, 3, 3, 3};
    logic             rv;
    logic [1:0]       rs;
    logic [WIDTH-1:0] rd;
    logic [2:0]       ra;

    rst = 1'b0;
    in_valid = 1'b0; in_sel = 2'b00; in_data = '0;
    out0_ack = 1'b0; out1_ack = 1'b0; out2_ack = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll("reset");
    rst = 1'b1;

    $display("[TB] test 1: single word to ch0");
    applyStimulus(1'b1, 2'b00, 8'h5A, 3'b000, "t1");
    checkOutput("t1_out0_data", 32'(out0_data), 32'h5A);
    checkOutput("t1_out1_valid", 32'(out1_valid), 32'h0);
    applyStimulus(1'b0, 2'b00, 8'h00, 3'b000, "t1_idle");

    $display("[TB] test 2: full channel back-pressure and ack pass-through");
    applyStimulus(1'b1, 2'b01, 8'h11, 3'b000, "t2_fill");
    applyStimulus(1'b1, 2'b01, 8'h22, 3'b000, "t2_stall");
    checkOutput("t2_stall_ready_lit", 32'(lastStalled), 32'h1);
    checkOutput("t2_hold_data", 32'(out1_data), 32'h11);
    applyStimulus(1'b1, 2'b01, 8'h22, 3'b010, "t2_ack");
    checkOutput("t2_new_data", 32'(out1_data), 32'h22);
    checkOutput("t2_new_valid", 32'(out1_valid), 32'h1);

    $display("[TB] test 3: streaming ch2 with ack held");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 2'b10, 8'(i), 3'b100, $sformatf("t3_%0d", i));
      checkOutput($sformatf("t3_data_%0d", i), 32'(out2_data), 32'(i));
    end

    $display("[TB] test 4: fill all, ack all at once");
    applyStimulus(1'b1, 2'b00, 8'hAA, 3'b001, "t4_f0");
    applyStimulus(1'b1, 2'b01, 8'hBB, 3'b010, "t4_f1");
    applyStimulus(1'b1, 2'b10, 8'hCC, 3'b100, "t4_f2");
    applyStimulus(1'b0, 2'b00, 8'h00, 3'b111, "t4_ack");
    checkOutput("t4_valids", 32'({out2_valid, out1_valid, out0_valid}), 32'h0);
    checkOutput("t4_keep0", 32'(out0_data), 32'hAA);
    checkOutput("t4_keep1", 32'(out1_data), 32'hBB);
    checkOutput("t4_keep2", 32'(out2_data), 32'hCC);

    $display("[TB] test 5: drops saturate");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b11, 8'(i + 8'h70), 3'b000, $sformatf("t5_%0d", i));
      checkOutput($sformatf("t5_cnt_%0d", i), 32'(drop_cnt), 32'(dropSeq[i]));
    end

    $display("[TB] test 6: asynchronous reset mid-cycle");
    applyStimulus(1'b1, 2'b00, 8'h3C, 3'b000, "t6_fill");
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out0_valid), 32'h0);
    checkOutput("t6_async_data", 32'(out0_data), 32'h0);
    checkOutput("t6_async_drop", 32'(drop_cnt), 32'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 2'b00, 8'h5A, 3'b000, "t6_after");
    checkOutput("t6_after_data", 32'(out0_data), 32'h5A);

    $display("[TB] random phase");
    rs = 2'b00;
    rd = '0;
    rv = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!lastStalled) begin
        rv = ($urandom_range(0, 3) != 0);
        rs = 2'($urandom_range(0, 3));
        rd = 8'($urandom);
      end
      ra = 3'($urandom_range(0, 7));
      applyStimulus(rv, rs, rd, ra, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
